mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, address width of masters and slave bus.
REQ-002 SHALL have parameter DATA_W, default 8, data width of masters and slave bus.
REQ-003 SHALL have parameter TIMEOUT, default 15, range 1-255: wait cycles without ack before a transfer is errored.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 m0_cyc_i, m0_stb_i, m0_we_i  input  1 each  master 0 (core data port) cycle, strobe, write-enable.
REQ-007 m0_adr_i  input  ADDR_W; m0_dat_i  input  DATA_W  master 0 address, write data.
REQ-008 m0_dat_o  output  DATA_W; m0_ack_o, m0_err_o  output  1  master 0 read data, ack, timeout error.
REQ-009 m1_* SHALL mirror REQ-006..008 exactly for master 1 (secondary requester, e.g. debug/DMA).
REQ-010 s_cyc_o, s_stb_o, s_we_o  output  1; s_adr_o  output  ADDR_W; s_dat_o  output  DATA_W  shared slave bus.
REQ-011 s_dat_i  input  DATA_W; s_ack_i  input  1  slave read data, ack.
REQ-012 grant_o  output  2  one-hot grant status: bit0 master 0, bit1 master 1, 00 idle.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT0, GRANT1; grant_o SHALL be registered state decode.
REQ-014 IDLE: request = mX_cyc_i high; single request -> GRANTX next edge; none -> stay IDLE.
REQ-015 IDLE, both requesting same cycle: grant to master not equal to last_grant (round-robin); last_grant updates on entry to GRANTX.
REQ-016 Grant latency: cyc sampled high in cycle N -> s_cyc_o high in cycle N+1.
REQ-017 GRANTX: s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o SHALL combinationally equal granted master's inputs; when not granted all SHALL be 0.
REQ-018 s_ack_i SHALL route combinationally to granted master's ack_o only; non-granted ack_o SHALL be 0.
REQ-019 s_dat_i SHALL route to granted master's dat_o; non-granted dat_o SHALL be 0.
REQ-020 Grant SHALL be held while granted mX_cyc_i high, regardless of other master's request (bus lock for multi-beat cycles).
REQ-021 Granted mX_cyc_i low at an edge -> IDLE; one idle cycle SHALL separate successive grants.
REQ-022 Master dropping cyc without ack (abort): s_cyc_o/s_stb_o SHALL fall same cycle; no ack or err issued.
REQ-023 Wait counter (8 bits): increments each GRANTX cycle with granted stb high and s_ack_i low; clears on ack, on stb low, on state change, and after an error.
REQ-024 Counter == TIMEOUT with s_ack_i low: granted mX_err_o SHALL be 1 for that cycle, s_stb_o forced 0 that cycle, counter cleared; grant retained.
REQ-025 Error therefore appears in the (TIMEOUT+1)th consecutive un-acked strobe cycle; ack and err SHALL never assert together.
REQ-026 s_ack_i in IDLE or while stb low SHALL be ignored and not alter state.

Reset
REQ-027 rst_n_i low SHALL asynchronously force state IDLE, last_grant = 1 (master 0 wins first tie), counter 0.
REQ-028 During and after reset until a grant: grant_o = 00, all s_* outputs 0, all mX_ack_o/mX_err_o/mX_dat_o 0.
REQ-029 Reset mid-transfer SHALL drop s_cyc_o/s_stb_o immediately, without waiting for clk; no ack forwarded.

Verification
REQ-030 Both cyc rise same cycle after reset -> grant_o=01 next cycle; m0 released -> IDLE 1 cycle -> grant_o=10.
REQ-031 m0 write adr 0x3C dat 0xA5, slave acks after 2 waits -> s_adr_o=0x3C, s_dat_o=0xA5, s_we_o=1, m0_ack_o 1 cycle, m1_ack_o 0.
REQ-032 m1 read, s_dat_i=0x5A with ack -> m1_dat_o=0x5A, m0_dat_o=0x00; m0 requesting meanwhile stays blocked until m1 cyc drops.
REQ-033 TIMEOUT=3, m0 stb held, no ack -> m0_err_o high in 4th strobe cycle, s_stb_o 0 that cycle, counter restarts, grant_o stays 01.
REQ-034 Alternating continuous requests from both -> grants strictly alternate 01,10,01 (round-robin, no starvation).
REQ-035 rst_n_i low mid-read between edges -> s_cyc_o, grant_o, acks 0 immediately; after release m0 wins first tie.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of both requester ports and the shared slave bus of the two-master arbiter.
// Signal suffixes are from the arbiter's point of view (slave modport).
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              m0_cyc_i, m0_stb_i, m0_we_i;
  logic [ADDR_W-1:0] m0_adr_i;
  logic [DATA_W-1:0] m0_dat_i;
  logic [DATA_W-1:0] m0_dat_o;
  logic              m0_ack_o, m0_err_o;

  logic              m1_cyc_i, m1_stb_i, m1_we_i;
  logic [ADDR_W-1:0] m1_adr_i;
  logic [DATA_W-1:0] m1_dat_i;
  logic [DATA_W-1:0] m1_dat_o;
  logic              m1_ack_o, m1_err_o;

  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [ADDR_W-1:0] s_adr_o;
  logic [DATA_W-1:0] s_dat_o;
  logic [DATA_W-1:0] s_dat_i;
  logic              s_ack_i;

  // Arbiter side
  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i
  );

  // Environment side: the two requesters and the slave device
  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for a single shared slave bus, with bus lock
// while the granted master holds cyc and a per-strobe ack timeout.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n_i,
  mem_bus_arbiter_if.slave bus,
  output logic [1:0]       grant_o
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [1:0]  grant_q, grant_d;

  logic              sel_cyc, sel_stb, sel_we;
  logic [ADDR_W-1:0] sel_adr;
  logic [DATA_W-1:0] sel_dat;
  logic              timeout_hit, ack_fwd;

  always_comb begin
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    sel_we  = 1'b0;
    sel_adr = '0;
    sel_dat = '0;
    case (state_q)
      GRANT0: begin
        sel_cyc = bus.m0_cyc_i;
        sel_stb = bus.m0_stb_i;
        sel_we  = bus.m0_we_i;
        sel_adr = bus.m0_adr_i;
        sel_dat = bus.m0_dat_i;
      end
      GRANT1: begin
        sel_cyc = bus.m1_cyc_i;
        sel_stb = bus.m1_stb_i;
        sel_we  = bus.m1_we_i;
        sel_adr = bus.m1_adr_i;
        sel_dat = bus.m1_dat_i;
      end
      default: ;
    endcase

    // An aborted cycle (cyc dropped) never produces ack or err
    timeout_hit = sel_cyc & sel_stb & ~bus.s_ack_i & (wait_cnt_q == TIMEOUT_CNT);
    ack_fwd     = sel_cyc & sel_stb & bus.s_ack_i;

    bus.s_cyc_o = sel_cyc;
    bus.s_stb_o = sel_stb & ~timeout_hit;
    bus.s_we_o  = sel_we;
    bus.s_adr_o = sel_adr;
    bus.s_dat_o = sel_dat;

    bus.m0_ack_o = (state_q == GRANT0) & ack_fwd;
    bus.m1_ack_o = (state_q == GRANT1) & ack_fwd;
    bus.m0_err_o = (state_q == GRANT0) & timeout_hit;
    bus.m1_err_o = (state_q == GRANT1) & timeout_hit;
    bus.m0_dat_o = (state_q == GRANT0) ? bus.s_dat_i : '0;
    bus.m1_dat_o = (state_q == GRANT1) ? bus.s_dat_i : '0;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (bus.m0_cyc_i && bus.m1_cyc_i) begin
          state_d      = last_grant_q ? GRANT0 : GRANT1;
          last_grant_d = ~last_grant_q;
        end else if (bus.m0_cyc_i) begin
          state_d      = GRANT0;
          last_grant_d = 1'b0;
        end else if (bus.m1_cyc_i) begin
          state_d      = GRANT1;
          last_grant_d = 1'b1;
        end
      end
      GRANT0, GRANT1: begin
        if (!sel_cyc) begin
          state_d = IDLE;
        end else if (!timeout_hit && sel_stb && !bus.s_ack_i) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      GRANT0:  grant_d = 2'b01;
      GRANT1:  grant_d = 2'b10;
      default: grant_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      wait_cnt_q   <= '0;
      grant_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      grant_q      <= grant_d;
    end
  end

  assign grant_o = grant_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scoreboard bench for mem_bus_arbiter (TIMEOUT=3): expectations are
// queued when stimulus is applied and popped against DUT outputs at the falling edge.
module tb_mem_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] grant;
  int         errors = 0;
  int         checks = 0;

  string       exp_tag_q[$];
  logic [31:0] exp_val_q[$];

  mem_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(3)) dut (
    .clk     (clk),
    .rst_n_i (rst_n),
    .bus     (bus),
    .grant_o (grant)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    end else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_tag_q.push_back(tag);
    exp_val_q.push_back(v);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    string       t;
    logic [31:0] v;
    if (exp_val_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_underflow observed=%0h expected=none", obs);
    end else begin
      t = exp_tag_q.pop_front();
      v = exp_val_q.pop_front();
      chk(t, obs, v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant_nz();
    int n = 0;
    @(negedge clk);
    while (grant == 2'b00 && n < 10) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_we_i = 0; bus.m0_adr_i = '0; bus.m0_dat_i = '0;
    bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0; bus.m1_adr_i = '0; bus.m1_dat_i = '0;
    bus.s_dat_i  = '0; bus.s_ack_i = 0;

    // Reset state
    sb_push("rst_grant", 0); sb_push("rst_s_cyc", 0); sb_push("rst_m0_ack", 0); sb_push("rst_m1_dat", 0);
    #12;
    sb_pop(grant); sb_pop(bus.s_cyc_o); sb_pop(bus.m0_ack_o); sb_pop(bus.m1_dat_o);
    @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous request: no grant in the request cycle, master 0 wins the first tie
    step();
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_adr_i = 8'h10;
    bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_adr_i = 8'h20;
    sb_push("tie_req_grant", 0); sb_push("tie_req_s_cyc", 0);
    @(negedge clk); sb_pop(grant); sb_pop(bus.s_cyc_o);

    step();
    bus.s_ack_i = 1;
    sb_push("tie_grant", 2'b01); sb_push("tie_s_adr", 8'h10);
    sb_push("tie_m0_ack", 1); sb_push("tie_m1_ack", 0);
    @(negedge clk); sb_pop(grant); sb_pop(bus.s_adr_o); sb_pop(bus.m0_ack_o); sb_pop(bus.m1_ack_o);

    // m0 releases; s_cyc falls in the same cycle, grant holds until the edge
    step();
    bus.s_ack_i = 0; bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
    sb_push("rel_s_cyc", 0); sb_push("rel_grant", 2'b01);
    @(negedge clk); sb_pop(bus.s_cyc_o); sb_pop(grant);

    // Idle gap; m0 re-requests with a write so m1 must win by round-robin
    step();
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_we_i = 1; bus.m0_adr_i = 8'h3C; bus.m0_dat_i = 8'hA5;
    sb_push("gap_grant", 0);
    @(negedge clk); sb_pop(grant);

    // m1 read with data returned
    step();
    bus.s_dat_i = 8'h5A; bus.s_ack_i = 1;
    sb_push("rd_grant", 2'b10); sb_push("rd_m1_dat", 8'h5A); sb_push("rd_m0_dat", 0);
    sb_push("rd_m1_ack", 1); sb_push("rd_m0_ack", 0); sb_push("rd_s_we", 0); sb_push("rd_s_adr", 8'h20);
    @(negedge clk);
    sb_pop(grant); sb_pop(bus.m1_dat_o); sb_pop(bus.m0_dat_o);
    sb_pop(bus.m1_ack_o); sb_pop(bus.m0_ack_o); sb_pop(bus.s_we_o); sb_pop(bus.s_adr_o);

    // m0 stays blocked while m1 holds cyc
    step();
    bus.s_ack_i = 0; bus.s_dat_i = '0; bus.m1_stb_i = 0;
    sb_push("lock1_grant", 2'b10); sb_push("lock1_m0_ack", 0);
    @(negedge clk); sb_pop(grant); sb_pop(bus.m0_ack_o);
    step();
    bus.s_ack_i = 1;
    sb_push("lock2_grant", 2'b10); sb_push("lock2_m1_ack_stb_low", 0);
    @(negedge clk); sb_pop(grant); sb_pop(bus.m1_ack_o);
    step();
    bus.s_ack_i = 0; bus.m1_cyc_i = 0;
    sb_push("m1rel_s_cyc", 0);
    @(negedge clk); sb_pop(bus.s_cyc_o);
    step();
    sb_push("gap2_grant", 0);
    @(negedge clk); sb_pop(grant);

    // m0 write, slave acks after two wait cycles
    step();
    sb_push("wr_grant", 2'b01); sb_push("wr_s_adr", 8'h3C); sb_push("wr_s_dat", 8'hA5);
    sb_push("wr_s_we", 1); sb_push("wr_wait1_ack", 0);
    @(negedge clk);
    sb_pop(grant); sb_pop(bus.s_adr_o); sb_pop(bus.s_dat_o); sb_pop(bus.s_we_o); sb_pop(bus.m0_ack_o);
    step();
    sb_push("wr_wait2_ack", 0);
    @(negedge clk); sb_pop(bus.m0_ack_o);
    step();
    bus.s_ack_i = 1;
    sb_push("wr_m0_ack", 1); sb_push("wr_m1_ack", 0); sb_push("wr_m0_err", 0);
    @(negedge clk); sb_pop(bus.m0_ack_o); sb_pop(bus.m1_ack_o); sb_pop(bus.m0_err_o);
    step();
    bus.s_ack_i = 0; bus.m0_stb_i = 0;
    sb_push("wr_done_ack", 0); sb_push("wr_done_err", 0);
    @(negedge clk); sb_pop(bus.m0_ack_o); sb_pop(bus.m0_err_o);

    // Timeout: strobe held without ack, error in every 4th strobe cycle
    for (int k = 1; k <= 8; k++) begin
      step();
      bus.m0_stb_i = 1;
      sb_push($sformatf("to%0d_err", k), (k % 4 == 0) ? 1 : 0);
      sb_push($sformatf("to%0d_s_stb", k), (k % 4 == 0) ? 0 : 1);
      sb_push($sformatf("to%0d_grant", k), 2'b01);
      @(negedge clk); sb_pop(bus.m0_err_o); sb_pop(bus.s_stb_o); sb_pop(grant);
    end
    step();
    bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_we_i = 0;

    // Continuous requests from both: grants alternate (last grant was m0)
    step();
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
    sb_push("rr1_grant", 2'b10); sb_push("rr2_grant", 2'b01);
    sb_push("rr3_grant", 2'b10); sb_push("rr4_grant", 2'b01);
    for (int r = 0; r < 4; r++) begin
      logic [1:0] g;
      wait_grant_nz();
      g = grant;
      sb_pop(g);
      step();
      if (g == 2'b01) bus.m0_cyc_i = 0;
      if (g == 2'b10) bus.m1_cyc_i = 0;
      step();
      bus.m0_cyc_i = 1; bus.m1_cyc_i = 1;
    end

    // Let m1 take and release its turn so m0 is the last granted before reset
    step();
    bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
    step();
    wait_grant_nz();
    sb_push("pre_rst_grant", 2'b01);
    sb_pop(grant);

    // Reset asserted between edges in the middle of an m0 read
    bus.s_dat_i = 8'h99; bus.s_ack_i = 1;
    sb_push("pre_rst_m0_ack", 1);
    #1; sb_pop(bus.m0_ack_o);
    #1; rst_n = 1'b0;
    sb_push("arst_s_cyc", 0); sb_push("arst_s_stb", 0); sb_push("arst_grant", 0);
    sb_push("arst_m0_ack", 0); sb_push("arst_m0_dat", 0);
    #1;
    sb_pop(bus.s_cyc_o); sb_pop(bus.s_stb_o); sb_pop(grant); sb_pop(bus.m0_ack_o); sb_pop(bus.m0_dat_o);
    bus.s_ack_i = 0; bus.s_dat_i = '0;
    bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
    step();
    sb_push("in_rst_grant", 0);
    sb_pop(grant);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    sb_push("post_rst_tie_grant", 2'b01);
    sb_pop(grant);

    step();
    bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
    if (exp_val_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_val_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
